// File: rtl/pri_encoder_q.sv
// pri_encoder_q: registered priority encoder with a sticky pending register.
// Request pulses set pending bits; one encoded index at a time is offered on
// a valid/ready output, and a pending bit clears only when its index is
// accepted. MODE 0 = fixed priority (highest index wins), MODE 1 = round-robin
// searching downward from a pointer, wrapping at N-1.
//
// Handshake: out_valid/out form a standard valid/ready pair. Once out_valid is
// high, out and out_valid stay constant until a cycle with out_ready high
// (accept = out_valid & out_ready); nothing newer, even a higher-priority
// request, can replace the offered index before it is accepted.
module pri_encoder_q #(
    parameter int N    = 8,
    parameter int W    = 3,
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out,
    output logic [N-1:0] pending,
    output logic         busy
);

    logic [N-1:0] pending_q, pending_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_q, out_d;
    logic [W-1:0] ptr_q, ptr_d;

    logic         accept;
    logic         load;
    logic [N-1:0] clr_mask;
    logic [N-1:0] sel_in;
    logic [W-1:0] eff_ptr;
    logic [W-1:0] pick_idx;
    logic         pick_found;

    // Accept, clear mask and pending update; a same-cycle req beats the clear.
    always_comb begin
        accept    = out_valid_q & out_ready;
        clr_mask  = accept ? ({{(N-1){1'b0}}, 1'b1} << out_q) : '0;
        sel_in    = pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | req;
        load      = ~out_valid_q | accept;
        // Round-robin starts just below the index being accepted this cycle.
        if (accept) begin
            eff_ptr = (out_q == '0) ? W'(N - 1) : out_q - W'(1);
        end else begin
            eff_ptr = ptr_q;
        end
    end

    // Pick one set bit of sel_in; later loop iterations have higher priority.
    always_comb begin
        logic [W-1:0] cand;
        int           idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        idx        = 0;
        if (MODE == 0) begin
            // Ascending scan: the highest set index is assigned last and wins.
            for (int i = 0; i < N; i++) begin
                cand = W'(i);
                if (sel_in[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end else begin
            // Scan from the farthest candidate toward eff_ptr, so eff_ptr wins
            // and the order below it descends with wrap at N-1.
            for (int k = N - 1; k >= 0; k--) begin
                idx = int'(eff_ptr) - k;
                if (idx < 0) begin
                    idx = idx + N;
                end
                cand = idx[W-1:0];
                if (sel_in[cand]) begin
                    pick_found = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

    // Output stage and pointer next-state: load when empty or being accepted.
    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = |sel_in;
            if (pick_found) begin
                out_d = pick_idx;
            end
        end
        if (accept && (MODE == 1)) begin
            ptr_d = eff_ptr;
        end
    end

    // State registers with synchronous active-high reset; req is ignored in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            ptr_q       <= W'(N - 1);
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign pending   = pending_q;
    assign busy      = |pending_q;

endmodule

// File: tb/tb_pri_encoder_q.sv
// Bench for pri_encoder_q: three instances (fixed N=8, round-robin N=8,
// round-robin N=5) share one stimulus stream; a behavioural model tracks each.
module tb_pri_encoder_q;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rdy;

    logic       v0, v1, v2;
    logic [2:0] o0, o1, o2;
    logic [7:0] p0, p1;
    logic [4:0] p2;
    logic       b0, b1, b2;

    int n_checks = 0;
    int n_errors = 0;

    pri_encoder_q #(.N(8), .W(3), .MODE(0)) u_fix8 (
        .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
        .out_valid(v0), .out(o0), .pending(p0), .busy(b0)
    );

    pri_encoder_q #(.N(8), .W(3), .MODE(1)) u_rr8 (
        .clk(clk), .rst(rst), .req(req), .out_ready(rdy),
        .out_valid(v1), .out(o1), .pending(p1), .busy(b1)
    );

    pri_encoder_q #(.N(5), .W(3), .MODE(1)) u_rr5 (
        .clk(clk), .rst(rst), .req(req[4:0]), .out_ready(rdy),
        .out_valid(v2), .out(o2), .pending(p2), .busy(b2)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural reference model ----------------
    int cfg_n[3]    = '{8, 8, 5};
    int cfg_mode[3] = '{0, 1, 1};
    bit m_pend[3][8];
    bit m_valid[3];
    int m_out[3];
    int m_ptr[3];

    task automatic model_step();
        for (int d = 0; d < 3; d++) begin
            int n;
            bit acc;
            int g;
            bit sel[8];
            bit any;
            int pick;
            int p;
            int idx;
            n    = cfg_n[d];
            acc  = m_valid[d] && rdy;
            g    = m_out[d];
            any  = 1'b0;
            pick = 0;
            for (int i = 0; i < 8; i++) sel[i] = 1'b0;
            for (int i = 0; i < n; i++) sel[i] = m_pend[d][i] && !(acc && i == g);
            p = acc ? (g + n - 1) % n : m_ptr[d];
            if (!m_valid[d] || acc) begin
                if (cfg_mode[d] == 0) begin
                    for (int i = n - 1; i >= 0; i--)
                        if (sel[i] && !any) begin any = 1'b1; pick = i; end
                end else begin
                    for (int k = 0; k < n; k++) begin
                        idx = (p - k + n) % n;
                        if (sel[idx] && !any) begin any = 1'b1; pick = idx; end
                    end
                end
                m_valid[d] = any;
                if (any) m_out[d] = pick;
            end
            if (acc && cfg_mode[d] == 1) m_ptr[d] = p;
            for (int i = 0; i < n; i++) m_pend[d][i] = sel[i] | req[i];
            if (rst) begin
                for (int i = 0; i < 8; i++) m_pend[d][i] = 1'b0;
                m_valid[d] = 1'b0;
                m_out[d]   = 0;
                m_ptr[d]   = n - 1;
            end
        end
    endtask

    always @(posedge clk) model_step();

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 3; d++) begin
            logic [7:0] dp;
            logic       dv;
            logic       db;
            logic [2:0] dout;
            logic [7:0] mp;
            mp = '0;
            for (int i = 0; i < 8; i++) mp[i] = m_pend[d][i];
            case (d)
                0:       begin dv = v0; dout = o0; dp = p0; db = b0; end
                1:       begin dv = v1; dout = o1; dp = p1; db = b1; end
                default: begin dv = v2; dout = o2; dp = {3'b000, p2}; db = b2; end
            endcase
            chk($sformatf("valid%0d", d), 32'(dv), 32'(m_valid[d]));
            chk($sformatf("out%0d", d), 32'(dout), 32'(m_out[d]));
            chk($sformatf("pending%0d", d), 32'(dp), 32'(mp));
            chk($sformatf("busy%0d", d), 32'(db), 32'(mp != 8'h00));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'hFF;
        cycle();
        cycle();
        rst = 1'b0;
        req = 8'h00;
    endtask

    int seq_rr8[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};

    initial begin
        rst = 1'b1;
        req = 8'h00;
        rdy = 1'b0;

        // Reset with requests present: everything must come out clear.
        rdy = 1'b1;
        do_reset();
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_out", 32'(o0), 32'd0);
        chk("rst_pending", 32'(p0), 32'h00);
        chk("rst_busy", 32'(b0), 32'd0);

        // Fixed encode: two bits in one pulse, drained highest first.
        req = 8'b0010_0100;
        cycle();
        req = 8'h00;
        cycle();
        chk("enc_t2_valid", 32'(v0), 32'd1);
        chk("enc_t2_out", 32'(o0), 32'd5);
        cycle();
        chk("enc_t3_out", 32'(o0), 32'd2);
        cycle();
        chk("enc_t4_valid", 32'(v0), 32'd0);
        chk("enc_t4_pending", 32'(p0), 32'h00);

        // Backpressure: index 5 held while a higher request arrives.
        do_reset();
        rdy = 1'b0;
        req = 8'b0010_0100;
        cycle();
        req = 8'h00;
        cycle();
        chk("bp_first", 32'(o0), 32'd5);
        req = 8'h80;
        cycle();
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", 32'(v0), 32'd1);
            chk("bp_hold_out", 32'(o0), 32'd5);
            cycle();
        end
        rdy = 1'b1;
        cycle();
        chk("bp_next_out", 32'(o0), 32'd7);
        rdy = 1'b0;
        cycle();

        // Mode contrast under continuous requests and ready.
        do_reset();
        rdy = 1'b1;
        req = 8'hFF;
        cycle();
        for (int k = 0; k < 9; k++) begin
            cycle();
            chk("mc_fix_out", 32'(o0), (k % 2 == 0) ? 32'd7 : 32'd6);
            chk("mc_rr8_out", 32'(o1), 32'(seq_rr8[k]));
            chk("mc_rr5_out", 32'(o2), 32'(4 - (k % 5)));
            chk("mc_rr5_valid", 32'(v2), 32'd1);
        end
        req = 8'h00;

        // Same-bit collision: accept of 3 with req bit 3 in the same cycle.
        do_reset();
        rdy = 1'b1;
        req = 8'b0000_1000;
        cycle();
        req = 8'h00;
        cycle();
        chk("col_out3", 32'(o0), 32'd3);
        req = 8'b0000_1010;
        cycle();
        chk("col_pending", 32'(p0), 32'h0A);
        req = 8'h00;
        cycle();
        chk("col_fix_out", 32'(o0), 32'd3);
        chk("col_rr_out", 32'(o1), 32'd1);
        cycle();
        chk("col_rr_late", 32'(o1), 32'd3);
        cycle();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       req = 8'($urandom);
                1:       req = 8'(1 << $urandom_range(0, 7));
                default: req = 8'h00;
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
